window3_feeder: RTL

//  Producer side of the 3-input sorter: turns a serial sample stream, delimited

---
 rtl/window3_feeder_pkg.sv | 14 +
 rtl/window3_feeder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/window3_feeder_pkg.sv
// Shared definitions for the 3-sample window feeder: state encoding and default widths.
package window3_feeder_pkg;

  localparam int DW_DEFAULT    = 8;
  localparam int LEN_W_DEFAULT = 12;

  // 2'd3 is unused and recovers to ST_IDLE
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/window3_feeder.sv
// Serial line stream -> 3-sample sliding windows (prev, centre, next) with edge
// replication, valid/ready on both sides and a single registered output stage.
module window3_feeder
  import window3_feeder_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             in_eol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data1,
  output logic [DW-1:0]    out_data2,
  output logic [DW-1:0]    out_data3,
  output logic             out_sol,
  output logic             out_eol,
  output logic [LEN_W-1:0] out_idx
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DW-1:0]      r_prev;
  logic [DW-1:0]      r_cur;
  logic               r_first;
  logic [LEN_W-1:0]   r_idx;

  logic               r_vld_p1;
  logic [DW-1:0]      r_data1_p1;
  logic [DW-1:0]      r_data2_p1;
  logic [DW-1:0]      r_data3_p1;
  logic               r_sol_p1;
  logic               r_eol_p1;
  logic [LEN_W-1:0]   r_idx_p1;

  logic               w_load_ok;
  logic               w_in_ready;
  logic               w_acc;
  logic               w_emit;
  logic               w_flush_emit;

  // Next sample of the window: the incoming sample, or the centre replicated at line end.
  function automatic logic [DW-1:0] f_next_sample(input logic          flush,
                                                  input logic [DW-1:0] cur,
                                                  input logic [DW-1:0] nxt);
    return flush ? cur : nxt;
  endfunction

  assign w_load_ok = !r_vld_p1 || out_ready;

  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      ST_IDLE:  w_in_ready = 1'b1;
      ST_RUN:   w_in_ready = w_load_ok;
      default:  w_in_ready = 1'b0;
    endcase
  end

  assign w_acc = in_valid && w_in_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_emit       = 1'b0;
    w_flush_emit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acc) w_state_nxt = in_eol ? ST_FLUSH : ST_RUN;
      end
      ST_RUN: begin
        if (w_acc) begin
          w_emit      = 1'b1;
          w_state_nxt = in_eol ? ST_FLUSH : ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (w_load_ok) begin
          w_emit       = 1'b1;
          w_flush_emit = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Line-history stage: previous/centre samples and centre position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_prev  <= '0;
      r_cur   <= '0;
      r_first <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc && r_state == ST_IDLE) begin
        r_prev  <= in_data;
        r_cur   <= in_data;
        r_first <= 1'b1;
        r_idx   <= '0;
      end else if (w_acc && r_state == ST_RUN) begin
        r_prev  <= r_cur;
        r_cur   <= in_data;
        r_first <= 1'b0;
        r_idx   <= r_idx + 1'b1;
      end
    end
  end

  // Output stage p1: window registers, held while the sink stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1   <= 1'b0;
      r_data1_p1 <= '0;
      r_data2_p1 <= '0;
      r_data3_p1 <= '0;
      r_sol_p1   <= 1'b0;
      r_eol_p1   <= 1'b0;
      r_idx_p1   <= '0;
    end else if (w_emit) begin
      r_vld_p1   <= 1'b1;
      r_data1_p1 <= r_prev;
      r_data2_p1 <= r_cur;
      r_data3_p1 <= f_next_sample(w_flush_emit, r_cur, in_data);
      r_sol_p1   <= r_first;
      r_eol_p1   <= w_flush_emit;
      r_idx_p1   <= r_idx;
    end else if (r_vld_p1 && out_ready) begin
      r_vld_p1   <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_vld_p1;
  assign out_data1 = r_data1_p1;
  assign out_data2 = r_data2_p1;
  assign out_data3 = r_data3_p1;
  assign out_sol   = r_sol_p1;
  assign out_eol   = r_eol_p1;
  assign out_idx   = r_idx_p1;

endmodule
